// File: rtl/cacheline_burst_adaptor_pkg.sv
// Shared types and constants for the cache-line to memory-burst adaptor.
// The line/beat geometry and the FSM encoding live here.
package burst_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BURST_LEN   = LINE_WIDTH / BURST_WIDTH;
  localparam int S_OFFSET    = 5;
  localparam int ADDR_WIDTH  = 32;

  // Clears the line-offset bits so the memory sees line-aligned addresses.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
    {{(ADDR_WIDTH-S_OFFSET){1'b1}}, {S_OFFSET{1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [$clog2(BURST_LEN)-1:0] beat_t;

  typedef logic [BURST_LEN-1:0][BURST_WIDTH-1:0] line_t;

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Bundles the cache-side line port and the memory-side burst port.
// The adaptor is the slave; the cache/memory environment is the master.
interface cacheline_burst_adaptor_if;
  import burst_pkg::*;

  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Splits a cache-line read/write-back into a 4-beat memory burst and
// reassembles read beats into a line, answering with a one-cycle resp_o.
module cacheline_burst_adaptor
  import burst_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  cacheline_burst_adaptor_if.slave bus
);

  state_t                 r_state;
  state_t                 w_state_next;
  beat_t                  r_beat;
  beat_t                  w_beat_inc;
  line_t                  r_buf;
  line_t                  r_line;
  logic [BURST_WIDTH-1:0] r_burst;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic                   r_read;
  logic                   r_write;
  logic                   r_resp;
  logic                   w_read_next;
  logic                   w_write_next;
  logic                   w_resp_next;
  logic                   w_last_beat;

  assign w_beat_inc  = r_beat + beat_t'(1);
  assign w_last_beat = bus.resp_i && (r_beat == beat_t'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // A simultaneous read and write request resolves to READ.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.read_i)       w_state_next = READ;
        else if (bus.write_i) w_state_next = WRITE;
      end
      READ:    if (w_last_beat) w_state_next = DONE;
      WRITE:   if (w_last_beat) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake outputs are decoded from the next state and then registered.
  always_comb begin
    w_read_next  = (w_state_next == READ);
    w_write_next = (w_state_next == WRITE);
    w_resp_next  = (w_state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      r_resp  <= 1'b0;
      r_beat  <= '0;
      r_buf   <= '0;
      r_line  <= '0;
      r_burst <= '0;
      r_addr  <= '0;
    end else begin
      r_read  <= w_read_next;
      r_write <= w_write_next;
      r_resp  <= w_resp_next;
      unique case (r_state)
        IDLE: begin
          if (bus.read_i) begin
            r_addr <= bus.address_i & ADDR_MASK;
            r_beat <= '0;
          end else if (bus.write_i) begin
            r_addr  <= bus.address_i & ADDR_MASK;
            r_beat  <= '0;
            r_buf   <= bus.line_i;
            r_burst <= bus.line_i[BURST_WIDTH-1:0];
          end
        end
        READ: begin
          if (bus.resp_i) begin
            r_line[r_beat] <= bus.burst_i;
            r_beat         <= w_beat_inc;
          end
        end
        // Present the following slice so it is on the bus the cycle after the ack.
        WRITE: begin
          if (bus.resp_i) begin
            r_beat  <= w_beat_inc;
            r_burst <= r_buf[w_beat_inc];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.read_o    = r_read;
  assign bus.write_o   = r_write;
  assign bus.resp_o    = r_resp;
  assign bus.address_o = r_addr;
  assign bus.burst_o   = r_burst;
  assign bus.line_o    = r_line;

endmodule
